// File: rtl/gcd_scheduler.sv
// gcd_scheduler: round-robin front end that time-shares one external subtractive GCD datapath among NREQ requesters.
// Optional feature macro GCD_SCHEDULER_STATS_EN adds iter_count, the subtract-step count of the latest response.

module gcd_scheduler #(
    parameter int NREQ = 4,
    parameter int W    = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*W-1:0]       req_a,
    input  logic [NREQ*W-1:0]       req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic [W-1:0]            rsp_gcd,
    input  logic                    rsp_ready,
    output logic                    dp_ldA,
    output logic                    dp_ldB,
    output logic                    dp_sel1,
    output logic                    dp_sel2,
    output logic                    dp_sel_in,
    output logic [W-1:0]            dp_data_in,
    input  logic                    dp_lt,
    input  logic                    dp_gt,
    input  logic                    dp_eq,
    input  logic [W-1:0]            dp_aout,
`ifdef GCD_SCHEDULER_STATS_EN
    output logic [W-1:0]            iter_count,
`endif
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int IXW = IDW + 1;
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_A  = 3'd1,
        LOAD_B  = 3'd2,
        COMPARE = 3'd3,
        SUB_A   = 3'd4,
        SUB_B   = 3'd5,
        RESP    = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] rr_q, rr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   gcd_q, gcd_d;
    logic [IDW-1:0] grant_id_s;
    logic           grant_any_s;
    logic [W-1:0]   sel_a_s;
    logic [W-1:0]   sel_b_s;
    logic           zero_op_s;
`ifdef GCD_SCHEDULER_STATS_EN
    logic [W-1:0]   cnt_q, cnt_d;
    logic [W-1:0]   iter_q, iter_d;
`endif

    // First requesting index at or after ptr, wrapping modulo NREQ (ptr itself has top priority).
    function automatic logic [IDW-1:0] rr_pick(input logic [NREQ-1:0] valid, input logic [IDW-1:0] ptr);
        logic [IXW-1:0] raw;
        logic [IXW-1:0] idx;
        logic           found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            raw = {1'b0, ptr} + IXW'(i);
            idx = (raw >= IXW'(NREQ)) ? (raw - IXW'(NREQ)) : raw;
            if (!found && valid[idx[IDW-1:0]]) begin
                found   = 1'b1;
                rr_pick = idx[IDW-1:0];
            end else begin
                found   = found;
            end
        end
    endfunction

    // Arbitration and operand selection for the candidate requester.
    always_comb begin
        grant_any_s = |req_valid;
        grant_id_s  = rr_pick(req_valid, rr_q);
        sel_a_s     = {W{1'b0}};
        sel_b_s     = {W{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            sel_a_s = (grant_id_s == IDW'(i)) ? req_a[i*W +: W] : sel_a_s;
            sel_b_s = (grant_id_s == IDW'(i)) ? req_b[i*W +: W] : sel_b_s;
        end
        zero_op_s = (sel_a_s == {W{1'b0}}) || (sel_b_s == {W{1'b0}});
    end

    // Accept pulse; gated by rst_n so nothing is granted while reset is held.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = rst_n && (state_q == IDLE) && grant_any_s && (grant_id_s == IDW'(i));
        end
    end

    // Next-state and captured-operand logic.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        id_d    = id_q;
        a_d     = a_q;
        b_d     = b_q;
        gcd_d   = gcd_q;
`ifdef GCD_SCHEDULER_STATS_EN
        cnt_d   = cnt_q;
        iter_d  = iter_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_any_s) begin
                    rr_d = (grant_id_s == LAST_ID) ? {IDW{1'b0}} : (grant_id_s + IDW'(1));
                    id_d = grant_id_s;
                    a_d  = sel_a_s;
                    b_d  = sel_b_s;
`ifdef GCD_SCHEDULER_STATS_EN
                    cnt_d = {W{1'b0}};
`endif
                    if (zero_op_s) begin
                        // gcd(x,0)=x; the datapath is never touched for this case
                        gcd_d   = (sel_a_s == {W{1'b0}}) ? sel_b_s : sel_a_s;
`ifdef GCD_SCHEDULER_STATS_EN
                        iter_d  = {W{1'b0}};
`endif
                        state_d = RESP;
                    end else begin
                        state_d = LOAD_A;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_A:  state_d = LOAD_B;
            LOAD_B:  state_d = COMPARE;
            COMPARE: begin
                if (dp_eq) begin
                    gcd_d   = dp_aout;
`ifdef GCD_SCHEDULER_STATS_EN
                    iter_d  = cnt_q;
`endif
                    state_d = RESP;
                end else if (dp_gt) begin
                    state_d = SUB_A;
                end else if (dp_lt) begin
                    state_d = SUB_B;
                end else begin
                    state_d = COMPARE;
                end
            end
            SUB_A, SUB_B: begin
`ifdef GCD_SCHEDULER_STATS_EN
                cnt_d   = (cnt_q == {W{1'b1}}) ? cnt_q : (cnt_q + W'(1));
`endif
                state_d = COMPARE;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath controls decoded from the state register only.
    always_comb begin
        dp_ldA     = 1'b0;
        dp_ldB     = 1'b0;
        dp_sel1    = 1'b0;
        dp_sel2    = 1'b0;
        dp_sel_in  = 1'b0;
        dp_data_in = {W{1'b0}};
        case (state_q)
            LOAD_A: begin
                dp_sel_in  = 1'b1;
                dp_ldA     = 1'b1;
                dp_data_in = a_q;
            end
            LOAD_B: begin
                dp_sel_in  = 1'b1;
                dp_ldB     = 1'b1;
                dp_data_in = b_q;
            end
            SUB_A: begin
                dp_sel2 = 1'b1;
                dp_ldA  = 1'b1;
            end
            SUB_B: begin
                dp_sel1 = 1'b1;
                dp_ldB  = 1'b1;
            end
            default: begin
                dp_ldA = 1'b0;
            end
        endcase
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = id_q;
    assign rsp_gcd   = gcd_q;
`ifdef GCD_SCHEDULER_STATS_EN
    assign iter_count = iter_q;
`endif

    // State, arbitration pointer and operation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= {IDW{1'b0}};
            id_q    <= {IDW{1'b0}};
            a_q     <= {W{1'b0}};
            b_q     <= {W{1'b0}};
            gcd_q   <= {W{1'b0}};
`ifdef GCD_SCHEDULER_STATS_EN
            cnt_q   <= {W{1'b0}};
            iter_q  <= {W{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            gcd_q   <= gcd_d;
`ifdef GCD_SCHEDULER_STATS_EN
            cnt_q   <= cnt_d;
            iter_q  <= iter_d;
`endif
        end
    end

endmodule
